csa_stream_combiner: RTL and testbench



---
 rtl/csa_pkg.sv | 29 ++
 rtl/csa_stream_combiner_if.sv | 33 +++
 rtl/csa_combiner_core.sv | 29 ++
 rtl/csa_stream_combiner.sv | 152 +++++++++++++++
 tb/tb_csa_stream_combiner.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/csa_pkg.sv
// Shared widths, S-box bit mapping and combiner state type for the CSA stream combiner.
package csa_pkg;

  localparam int unsigned SBOX_OUT_W = 14;
  localparam int unsigned NIB_W      = 4;

  // Each entry is a sbox_out bit index; element [i] feeds nibble bit i.
  typedef logic [NIB_W-1:0][3:0] nib_idx_t;

  localparam nib_idx_t X_IDX = {4'd6, 4'd4, 4'd3, 4'd1};
  localparam nib_idx_t Y_IDX = {4'd10, 4'd8, 4'd7, 4'd5};
  localparam nib_idx_t Z_IDX = {4'd2, 4'd0, 4'd13, 4'd11};
  localparam int unsigned P_IDX = 13;
  localparam int unsigned Q_IDX = 12;

  typedef struct packed {
    logic [NIB_W-1:0] e;
    logic [NIB_W-1:0] f;
    logic             r;
  } comb_state_t;

  function automatic logic [NIB_W-1:0] pick_nib(input logic [SBOX_OUT_W-1:0] s,
                                                input nib_idx_t idx);
    logic [NIB_W-1:0] n;
    for (int i = 0; i < int'(NIB_W); i++) n[i] = s[idx[i]];
    return n;
  endfunction

endpackage

// File: rtl/csa_stream_combiner_if.sv
// Round-input, feedback and keystream signals between the S-box stage and the combiner.
interface csa_stream_combiner_if;
  import csa_pkg::*;

  logic                  init;
  logic                  gen_mode;
  logic                  s_valid;
  logic                  s_ready;
  logic [SBOX_OUT_W-1:0] sbox_out;
  logic [NIB_W-1:0]      b_extra;
  logic [NIB_W-1:0]      fb_x;
  logic [NIB_W-1:0]      fb_y;
  logic [NIB_W-1:0]      fb_z;
  logic                  fb_p;
  logic                  fb_q;
  logic [NIB_W-1:0]      fb_d;
  logic                  fb_valid;
  logic                  init_done;
  logic [7:0]            ks_byte;
  logic                  ks_valid;
  logic                  ks_ready;

  modport slave (
    input  init, gen_mode, s_valid, sbox_out, b_extra, ks_ready,
    output s_ready, fb_x, fb_y, fb_z, fb_p, fb_q, fb_d, fb_valid, init_done, ks_byte, ks_valid
  );

  modport master (
    output init, gen_mode, s_valid, sbox_out, b_extra, ks_ready,
    input  s_ready, fb_x, fb_y, fb_z, fb_p, fb_q, fb_d, fb_valid, init_done, ks_byte, ks_valid
  );

endinterface

// File: rtl/csa_combiner_core.sv
// Combinational E/F/carry update and D nibble for one combiner round.
module csa_combiner_core
  import csa_pkg::*;
(
  input  comb_state_t      state_i,
  input  logic [NIB_W-1:0] z_i,
  input  logic [NIB_W-1:0] b_extra_i,
  input  logic             q_i,
  output comb_state_t      state_o,
  output logic [NIB_W-1:0] d_o
);

  logic [NIB_W:0] sum;

  always_comb begin
    sum       = {1'b0, state_i.e} + {1'b0, z_i} + {{NIB_W{1'b0}}, state_i.r};
    d_o       = state_i.e ^ z_i ^ b_extra_i;
    state_o.e = state_i.f;
    if (q_i) begin
      state_o.f = sum[NIB_W-1:0];
      state_o.r = sum[NIB_W];
    end else begin
      // q=0 swaps E and F and holds the carry
      state_o.f = state_i.e;
      state_o.r = state_i.r;
    end
  end

endmodule

// File: rtl/csa_stream_combiner.sv
// Round handshake, feedback registers, init counting and keystream byte assembly.
module csa_stream_combiner
  import csa_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_BYTE = 4,
  parameter int unsigned INIT_ROUNDS     = 32
) (
  input logic                  clk,
  input logic                  rst,
  csa_stream_combiner_if.slave bus_io
);

  localparam int unsigned PhW  = $clog2(ROUNDS_PER_BYTE);
  localparam int unsigned ShW  = 2 * (ROUNDS_PER_BYTE - 1);
  localparam int unsigned CntW = $clog2(INIT_ROUNDS + 1);
  localparam logic [PhW-1:0]  LastPhase = PhW'(ROUNDS_PER_BYTE - 1);
  localparam logic [CntW-1:0] InitMax   = CntW'(INIT_ROUNDS);

  comb_state_t      state_q, state_d, core_state;
  logic [NIB_W-1:0] fb_x_q, fb_x_d, fb_y_q, fb_y_d, fb_z_q, fb_z_d, fb_d_q, fb_d_d;
  logic             fb_p_q, fb_p_d, fb_q_q, fb_q_d, fb_valid_q, fb_valid_d;
  logic [PhW-1:0]   phase_q, phase_d;
  logic [ShW-1:0]   shift_q, shift_d;
  logic [7:0]       ks_byte_q, ks_byte_d;
  logic             ks_valid_q, ks_valid_d;
  logic [CntW-1:0]  init_cnt_q, init_cnt_d;
  logic             init_done_q, init_done_d;
  logic             gen_mode_q;

  logic [NIB_W-1:0] x, y, z, d;
  logic             q, stall, accept;
  logic [1:0]       ks2;

  assign x   = pick_nib(bus_io.sbox_out, X_IDX);
  assign y   = pick_nib(bus_io.sbox_out, Y_IDX);
  assign z   = pick_nib(bus_io.sbox_out, Z_IDX);
  assign q   = bus_io.sbox_out[Q_IDX];
  assign ks2 = {d[3] ^ d[2], d[1] ^ d[0]};

  // Stall only when the round would load a byte over one still waiting.
  assign stall          = ks_valid_q && !bus_io.ks_ready && (phase_q == LastPhase);
  assign bus_io.s_ready = !stall && !bus_io.init;
  assign accept         = bus_io.s_valid && bus_io.s_ready;

  csa_combiner_core u_core (
    .state_i   (state_q),
    .z_i       (z),
    .b_extra_i (bus_io.b_extra),
    .q_i       (q),
    .state_o   (core_state),
    .d_o       (d)
  );

  always_comb begin
    state_d     = state_q;
    fb_x_d      = fb_x_q;
    fb_y_d      = fb_y_q;
    fb_z_d      = fb_z_q;
    fb_p_d      = fb_p_q;
    fb_q_d      = fb_q_q;
    fb_d_d      = fb_d_q;
    fb_valid_d  = 1'b0;
    // A mode change abandons any partially built byte.
    phase_d     = (bus_io.gen_mode != gen_mode_q) ? '0 : phase_q;
    shift_d     = (bus_io.gen_mode != gen_mode_q) ? '0 : shift_q;
    ks_byte_d   = ks_byte_q;
    ks_valid_d  = ks_valid_q && !bus_io.ks_ready;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    if (bus_io.init) begin
      state_d     = '0;
      phase_d     = '0;
      shift_d     = '0;
      ks_valid_d  = 1'b0;
      init_cnt_d  = '0;
      init_done_d = 1'b0;
    end else if (accept) begin
      state_d    = core_state;
      fb_x_d     = x;
      fb_y_d     = y;
      fb_z_d     = z;
      fb_p_d     = bus_io.sbox_out[P_IDX];
      fb_q_d     = q;
      fb_d_d     = d;
      fb_valid_d = 1'b1;
      if (bus_io.gen_mode) begin
        if (phase_d == LastPhase) begin
          ks_byte_d  = {shift_d, ks2};
          ks_valid_d = 1'b1;
          phase_d    = '0;
          shift_d    = '0;
        end else begin
          shift_d = {shift_d[ShW-3:0], ks2};
          phase_d = phase_d + PhW'(1);
        end
      end else begin
        phase_d = '0;
        shift_d = '0;
        if (init_cnt_q != InitMax) init_cnt_d = init_cnt_q + CntW'(1);
        if (init_cnt_d == InitMax) init_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= '0;
      fb_x_q      <= '0;
      fb_y_q      <= '0;
      fb_z_q      <= '0;
      fb_p_q      <= 1'b0;
      fb_q_q      <= 1'b0;
      fb_d_q      <= '0;
      fb_valid_q  <= 1'b0;
      phase_q     <= '0;
      shift_q     <= '0;
      ks_byte_q   <= '0;
      ks_valid_q  <= 1'b0;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      gen_mode_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fb_x_q      <= fb_x_d;
      fb_y_q      <= fb_y_d;
      fb_z_q      <= fb_z_d;
      fb_p_q      <= fb_p_d;
      fb_q_q      <= fb_q_d;
      fb_d_q      <= fb_d_d;
      fb_valid_q  <= fb_valid_d;
      phase_q     <= phase_d;
      shift_q     <= shift_d;
      ks_byte_q   <= ks_byte_d;
      ks_valid_q  <= ks_valid_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      gen_mode_q  <= bus_io.gen_mode;
    end
  end

  assign bus_io.fb_x      = fb_x_q;
  assign bus_io.fb_y      = fb_y_q;
  assign bus_io.fb_z      = fb_z_q;
  assign bus_io.fb_p      = fb_p_q;
  assign bus_io.fb_q      = fb_q_q;
  assign bus_io.fb_d      = fb_d_q;
  assign bus_io.fb_valid  = fb_valid_q;
  assign bus_io.init_done = init_done_q;
  assign bus_io.ks_byte   = ks_byte_q;
  assign bus_io.ks_valid  = ks_valid_q;

endmodule

// File: tb/tb_csa_stream_combiner.sv
// Directed bench for csa_stream_combiner with hand-computed expected values.
module tb_csa_stream_combiner;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  logic ks_seen;
  logic [13:0] s_cur;

  logic [3:0] t3_d [3] = '{4'h1, 4'h1, 4'h0};
  logic [3:0] t3_e [3] = '{4'h0, 4'h1, 4'h1};
  logic [3:0] t3_f [3] = '{4'h1, 4'h1, 4'h2};
  logic [3:0] t4_d [3] = '{4'hF, 4'hF, 4'h0};
  logic [3:0] t5_b [7] = '{4'h8, 4'h1, 4'hC, 4'hA, 4'hA, 4'h8, 4'h1};

  csa_stream_combiner_if bus ();

  csa_stream_combiner #(
    .ROUNDS_PER_BYTE (4),
    .INIT_ROUNDS     (32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic round(input logic [13:0] s, input logic [3:0] b);
    bus.sbox_out = s;
    bus.b_extra  = b;
    bus.s_valid  = 1'b1;
    step();
    bus.s_valid  = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic consume();
    bus.ks_ready = 1'b1;
    step();
    bus.ks_ready = 1'b0;
  endtask

  function automatic logic [13:0] sb(input logic [1:0] s1, s2, s3, s4, s5, s6, s7);
    return {s7, s6, s5, s4, s3, s2, s1};
  endfunction

  initial begin
    rst          = 1'b1;
    bus.init     = 1'b0;
    bus.gen_mode = 1'b1;
    bus.s_valid  = 1'b0;
    bus.sbox_out = '0;
    bus.b_extra  = '0;
    bus.ks_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    check_eq("rst_s_ready", 32'(bus.s_ready), 1);
    check_eq("rst_ks_valid", 32'(bus.ks_valid), 0);
    check_eq("rst_fb_valid", 32'(bus.fb_valid), 0);
    check_eq("rst_init_done", 32'(bus.init_done), 0);
    check_eq("rst_ks_byte", 32'(bus.ks_byte), 0);

    // All-zero rounds build a zero byte on the fourth accept.
    repeat (3) round('0, '0);
    check_eq("zero_ks_early", 32'(bus.ks_valid), 0);
    round('0, '0);
    check_eq("zero_ks_valid", 32'(bus.ks_valid), 1);
    check_eq("zero_ks_byte", 32'(bus.ks_byte), 0);
    check_eq("zero_fb_valid", 32'(bus.fb_valid), 1);
    check_eq("zero_fb_d", 32'(bus.fb_d), 0);
    consume();
    check_eq("zero_ks_consumed", 32'(bus.ks_valid), 0);
    check_eq("zero_fb_pulse", 32'(bus.fb_valid), 0);

    // s1=11 alone
    round(sb(2'b11, 0, 0, 0, 0, 0, 0), '0);
    check_eq("s1_fb_x", 32'(bus.fb_x), 32'h1);
    check_eq("s1_fb_y", 32'(bus.fb_y), 32'h0);
    check_eq("s1_fb_z", 32'(bus.fb_z), 32'h4);
    check_eq("s1_fb_d", 32'(bus.fb_d), 32'h4);
    check_eq("s1_fb_q", 32'(bus.fb_q), 0);
    check_eq("s1_e", 32'(dut.state_q.e), 0);
    check_eq("s1_f", 32'(dut.state_q.f), 0);
    repeat (3) round('0, '0);
    check_eq("s1_ks_byte", 32'(bus.ks_byte), 32'h80);
    consume();

    // Z=1, q=1 carry-chain rounds
    pulse_reset();
    s_cur = sb(0, 0, 0, 0, 0, 2'b10, 2'b01);
    for (int i = 0; i < 3; i++) begin
      round(s_cur, '0);
      check_eq($sformatf("z1_d%0d", i), 32'(bus.fb_d), 32'(t3_d[i]));
      check_eq($sformatf("z1_e%0d", i), 32'(dut.state_q.e), 32'(t3_e[i]));
      check_eq($sformatf("z1_f%0d", i), 32'(dut.state_q.f), 32'(t3_f[i]));
      check_eq($sformatf("z1_r%0d", i), 32'(dut.state_q.r), 0);
    end
    check_eq("z1_fb_z", 32'(bus.fb_z), 32'h1);
    check_eq("z1_fb_pq", 32'({bus.fb_p, bus.fb_q}), 32'h1);
    round('0, '0);
    check_eq("z1_ks_byte", 32'(bus.ks_byte), 32'h51);
    consume();

    // Z=F, q=1: third round carries out
    pulse_reset();
    s_cur = sb(2'b01, 2'b01, 0, 0, 0, 2'b10, 2'b11);
    for (int i = 0; i < 3; i++) begin
      round(s_cur, '0);
      check_eq($sformatf("zf_d%0d", i), 32'(bus.fb_d), 32'(t4_d[i]));
    end
    check_eq("zf_e", 32'(dut.state_q.e), 32'hF);
    check_eq("zf_f", 32'(dut.state_q.f), 32'hE);
    check_eq("zf_r", 32'(dut.state_q.r), 1);
    check_eq("zf_fb_z", 32'(bus.fb_z), 32'hF);
    check_eq("zf_fb_pq", 32'({bus.fb_p, bus.fb_q}), 32'h3);
    check_eq("zf_fb_x", 32'(bus.fb_x), 32'h0);

    // Backpressure: D follows b_extra while E=F=0 and q=0
    pulse_reset();
    for (int i = 0; i < 4; i++) round('0, t5_b[i]);
    check_eq("bp_ks_valid", 32'(bus.ks_valid), 1);
    check_eq("bp_byte0", 32'(bus.ks_byte), 32'h93);
    for (int i = 4; i < 7; i++) round('0, t5_b[i]);
    check_eq("bp_stall", 32'(bus.s_ready), 0);
    bus.sbox_out = '0;
    bus.b_extra  = 4'h8;
    bus.s_valid  = 1'b1;
    step();
    check_eq("bp_no_accept", 32'(bus.fb_valid), 0);
    check_eq("bp_byte_held", 32'(bus.ks_byte), 32'h93);
    bus.ks_ready = 1'b1;
    #1;
    check_eq("bp_ready_back", 32'(bus.s_ready), 1);
    step();
    bus.s_valid  = 1'b0;
    bus.ks_ready = 1'b0;
    check_eq("bp_valid_kept", 32'(bus.ks_valid), 1);
    check_eq("bp_byte1", 32'(bus.ks_byte), 32'hE6);
    consume();
    check_eq("bp_drained", 32'(bus.ks_valid), 0);

    // Mode flip mid-byte discards the partial byte
    pulse_reset();
    round(sb(2'b11, 0, 0, 0, 0, 0, 0), '0);
    round(sb(2'b11, 0, 0, 0, 0, 0, 0), '0);
    bus.gen_mode = 1'b0;
    step();
    bus.gen_mode = 1'b1;
    step();
    repeat (3) round('0, '0);
    check_eq("flip_ks_early", 32'(bus.ks_valid), 0);
    round('0, '0);
    check_eq("flip_ks_byte", 32'(bus.ks_byte), 32'h00);
    consume();

    // Init mode counting
    pulse_reset();
    bus.gen_mode = 1'b0;
    ks_seen      = 1'b0;
    s_cur        = sb(0, 0, 0, 0, 0, 2'b10, 2'b01);
    for (int i = 0; i < 31; i++) begin
      round(s_cur, '0);
      ks_seen |= bus.ks_valid;
    end
    check_eq("init_done_31", 32'(bus.init_done), 0);
    round(s_cur, '0);
    check_eq("init_done_32", 32'(bus.init_done), 1);
    repeat (2) begin
      round(s_cur, '0);
      ks_seen |= bus.ks_valid;
    end
    check_eq("init_done_sticky", 32'(bus.init_done), 1);
    check_eq("init_no_ks", 32'(ks_seen), 0);
    bus.init     = 1'b1;
    bus.s_valid  = 1'b1;
    bus.sbox_out = s_cur;
    #1;
    check_eq("init_s_ready", 32'(bus.s_ready), 0);
    step();
    bus.init    = 1'b0;
    bus.s_valid = 1'b0;
    check_eq("init_clr_done", 32'(bus.init_done), 0);
    check_eq("init_drop_round", 32'(bus.fb_valid), 0);
    check_eq("init_clr_ef", 32'({dut.state_q.e, dut.state_q.f, dut.state_q.r}), 0);

    // Reset in the middle of a byte
    bus.gen_mode = 1'b1;
    round(sb(2'b11, 0, 0, 0, 0, 0, 0), '0);
    round(sb(2'b11, 0, 0, 0, 0, 0, 0), '0);
    check_eq("mid_fb_x", 32'(bus.fb_x), 32'h1);
    pulse_reset();
    check_eq("mid_fb_x_clr", 32'(bus.fb_x), 0);
    check_eq("mid_fb_z_clr", 32'(bus.fb_z), 0);
    check_eq("mid_fb_d_clr", 32'(bus.fb_d), 0);
    check_eq("mid_fb_valid_clr", 32'(bus.fb_valid), 0);
    check_eq("mid_s_ready", 32'(bus.s_ready), 1);
    repeat (3) round('0, '0);
    check_eq("mid_ks_early", 32'(bus.ks_valid), 0);
    round('0, '0);
    check_eq("mid_ks_byte", 32'(bus.ks_byte), 32'h00);
    check_eq("mid_ks_valid", 32'(bus.ks_valid), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
